// File: rtl/tm1637_frame.sv
// TM1637 multi-byte frame master: START, LSB-first bytes with ACK, optional key-scan read, STOP.
// Define TM1637_ACK_CHECK_EN to abort on NAK (sets err, drains the rest of the frame).
module tm1637_frame #(
  parameter int WAIT_CYCLES = 256,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_read,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       err,
  output logic       scl_en,
  output logic       scl_out,
  output logic       sda_en,
  output logic       sda_out,
  input  logic       sda_in
);

  // state | meaning: IDLE wait frame | START sda low | BIT_LO/BIT_HI write bit | ACK_LO/ACK_HI/ACK_END ack slot
  // LOAD hold bus low, wait next byte | RD_LO/RD_HI read bit | STOP1/STOP2 stop | DRAIN discard to tx_last
  localparam logic [3:0] S_IDLE = 4'd0, S_START = 4'd1, S_BIT_LO = 4'd2, S_BIT_HI = 4'd3,
                         S_ACK_LO = 4'd4, S_ACK_HI = 4'd5, S_ACK_END = 4'd6, S_LOAD = 4'd7,
                         S_RD_LO = 4'd8, S_RD_HI = 4'd9, S_STOP1 = 4'd10, S_STOP2 = 4'd11,
                         S_DRAIN = 4'd12;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
`ifdef TM1637_ACK_CHECK_EN
  localparam logic ACK_CHK = 1'b1;
`else
  localparam logic ACK_CHK = 1'b0;
`endif

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             last_q, last_d, read_q, read_d, rd_phase_q, rd_phase_d;
  logic             nak_q, nak_d, err_q, err_d;
  logic             scl_q, scl_d, sda_q, sda_d, busy_q, busy_d, rx_valid_q, rx_valid_d;
  logic             rdy_en_q;
  logic             accept, phase_end;

  assign tx_ready  = rdy_en_q && (state_q == S_IDLE || state_q == S_LOAD || state_q == S_DRAIN);
  assign accept    = tx_valid && tx_ready;
  assign phase_end = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    last_d     = last_q;
    read_d     = read_q;
    rd_phase_d = rd_phase_q;
    nak_d      = nak_q;
    err_d      = err_q;
    rx_shift_d = rx_shift_q;
    case (state_q)
      S_IDLE: if (accept) begin
        byte_d     = tx_data;
        last_d     = tx_last;
        read_d     = tx_last && tx_read;
        rd_phase_d = 1'b0;
        nak_d      = 1'b0;
        err_d      = 1'b0;
        state_d    = S_START;
      end
      S_START: if (phase_end) begin
        bit_d   = 3'd0;
        state_d = S_BIT_LO;
      end
      S_BIT_LO: if (phase_end) state_d = S_BIT_HI;
      S_BIT_HI: if (phase_end) begin
        if (bit_q == 3'd7) state_d = S_ACK_LO;
        else begin
          bit_d   = bit_q + 3'd1;
          state_d = S_BIT_LO;
        end
      end
      S_ACK_LO: if (phase_end) state_d = S_ACK_HI;
      S_ACK_HI: if (phase_end) begin
        state_d = S_ACK_END;
        if (ACK_CHK && !rd_phase_q && sda_in) begin
          nak_d = 1'b1;
          err_d = 1'b1;
        end
      end
      S_ACK_END: if (phase_end) begin
        if (nak_q || rd_phase_q) state_d = S_STOP1;
        else if (read_q) begin
          bit_d      = 3'd0;
          rd_phase_d = 1'b1;
          state_d    = S_RD_LO;
        end
        else if (last_q) state_d = S_STOP1;
        else state_d = S_LOAD;
      end
      S_LOAD: if (accept) begin
        byte_d  = tx_data;
        last_d  = tx_last;
        read_d  = tx_last && tx_read;
        bit_d   = 3'd0;
        state_d = S_BIT_LO;
      end
      S_RD_LO: if (phase_end) state_d = S_RD_HI;
      S_RD_HI: if (phase_end) begin
        rx_shift_d[bit_q] = sda_in;
        if (bit_q == 3'd7) state_d = S_ACK_LO;
        else begin
          bit_d   = bit_q + 3'd1;
          state_d = S_RD_LO;
        end
      end
      S_STOP1: if (phase_end) state_d = S_STOP2;
      S_STOP2: if (phase_end) state_d = (nak_q && !last_q) ? S_DRAIN : S_IDLE;
      S_DRAIN: if (accept && tx_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Every phase reloads on entry, so consecutive phases never share a count.
    if (state_d != state_q) cnt_d = CNT_LOAD;
    else if (!phase_end) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state_d)
      S_START:  sda_d = 1'b1;
      S_BIT_LO: begin
        scl_d = 1'b1;
        sda_d = ~byte_d[bit_d];
      end
      S_BIT_HI: sda_d = ~byte_d[bit_d];
      S_ACK_LO, S_RD_LO: scl_d = 1'b1;
      S_ACK_END, S_LOAD: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
      S_STOP1:  sda_d = 1'b1;
      default:  ;
    endcase
    busy_d     = !(state_d == S_IDLE || state_d == S_DRAIN);
    rx_valid_d = (state_d == S_STOP1) && (state_q != S_STOP1) && rd_phase_q;
    rx_data_d  = rx_valid_d ? rx_shift_q : rx_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      read_q     <= 1'b0;
      rd_phase_q <= 1'b0;
      nak_q      <= 1'b0;
      err_q      <= 1'b0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      scl_q      <= 1'b0;
      sda_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      read_q     <= read_d;
      rd_phase_q <= rd_phase_d;
      nak_q      <= nak_d;
      err_q      <= err_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign scl_en   = scl_q;
  assign sda_en   = sda_q;
  assign scl_out  = 1'b0;
  assign sda_out  = 1'b0;
  assign busy     = busy_q;
  assign err      = err_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_tm1637_frame.sv
// Scoreboard bench for tm1637_frame: a bus monitor/slave decodes START, bytes and STOP and
// compares them, plus busy lengths and rx results, against queues filled by the stimulus.
module tb_tm1637_frame;

  localparam int W = 4;
  localparam int EV_START = 256;
  localparam int EV_STOP  = 512;
  localparam int EV_RD    = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_last, tx_read;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, busy, err;
  logic [7:0] rx_data;
  logic       scl_en, scl_out, sda_en, sda_out, sda_in;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_ev[$];
  int exp_busy[$];
  int exp_rx[$];

  logic       mon_en = 1'b1;
  logic       slave_low = 1'b0;
  int         slave_nak_idx = -1;
  int         slave_rd_idx  = -1;
  logic [7:0] slave_rd_val  = 8'h00;
  int         hs_cnt = 0;
  int         rxp_cnt = 0;
  int         viol = 0;

  always #5 clk = ~clk;

  assign sda_in = !(sda_en || slave_low);

  tm1637_frame #(.WAIT_CYCLES(W), .CNT_W(10)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_read(tx_read),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .err(err),
    .scl_en(scl_en), .scl_out(scl_out), .sda_en(sda_en), .sda_out(sda_out), .sda_in(sda_in)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic post_event(input int ev);
    if (exp_ev.size() == 0) chk("bus_event_unexpected", ev, -1);
    else chk("bus_event", ev, exp_ev.pop_front());
  endtask

  // Bus monitor plus slave model, sampled on the falling clock edge.
  logic       p_scl = 1'b1, p_sda = 1'b1, p_rxv = 1'b0;
  logic       scl_l, sda_l, is_rd;
  logic [7:0] shreg = 8'h00;
  int         bitcnt = 0, byte_idx = 0, busy_cnt = 0;

  always @(negedge clk) begin
    scl_l = !scl_en;
    sda_l = !(sda_en || slave_low);
    if (tx_valid && tx_ready) hs_cnt++;
    if (tx_ready && busy && !(scl_en && sda_en)) viol++;
    if (!mon_en) begin
      bitcnt = 0; byte_idx = 0; slave_low = 1'b0; busy_cnt = 0;
      scl_l = 1'b1; sda_l = 1'b1;
    end else begin
      is_rd = (byte_idx == slave_rd_idx);
      if (scl_l && p_scl && p_sda && !sda_l) begin
        post_event(EV_START);
        bitcnt = 0; byte_idx = 0;
      end else if (scl_l && p_scl && !p_sda && sda_l) begin
        post_event(EV_STOP);
      end else if (scl_l && !p_scl) begin
        if (bitcnt < 8) shreg[bitcnt] = sda_l;
        bitcnt++;
      end else if (!scl_l && p_scl) begin
        if (bitcnt == 8) begin
          post_event(is_rd ? (EV_RD | int'(shreg)) : int'(shreg));
          slave_low = !is_rd && (byte_idx != slave_nak_idx);
        end else if (bitcnt == 9) begin
          bitcnt = 0;
          byte_idx++;
          slave_low = (byte_idx == slave_rd_idx) && !slave_rd_val[0];
        end else if (is_rd && bitcnt > 0) begin
          slave_low = !slave_rd_val[bitcnt];
        end
      end
      if (busy) busy_cnt++;
      else if (busy_cnt > 0) begin
        if (exp_busy.size() == 0) chk("busy_len_unexpected", busy_cnt, -1);
        else chk("busy_len", busy_cnt, exp_busy.pop_front());
        busy_cnt = 0;
      end
      if (rx_valid) begin
        rxp_cnt++;
        if (p_rxv) chk("rx_valid_width", 2, 1);
        if (exp_rx.size() == 0) chk("rx_unexpected", int'(rx_data), -1);
        else chk("rx_data", int'(rx_data), exp_rx.pop_front());
      end
    end
    p_scl = scl_l;
    p_sda = sda_l;
    p_rxv = rx_valid;
  end

  task automatic send_frame(input logic [31:0] b, input int n, input logic rd,
                            input int stall_at, input int stall);
    logic ok;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
          @(negedge clk);
          if (tx_ready && busy) begin ok = 1'b1; break; end
        end
        if (!ok) chk("load_timeout", 0, 1);
        repeat (stall) @(posedge clk);
        #1;
      end
      tx_valid = 1'b1;
      tx_data  = b[8*i +: 8];
      tx_last  = (i == n - 1);
      tx_read  = rd && (i == n - 1);
      ok = 1'b0;
      for (int t = 0; t < 3000; t++) begin
        @(negedge clk);
        if (tx_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      if (i == n - 1 || i + 1 == stall_at) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_read  = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; tx_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl_en", scl_en, 0);
    chk("rst_sda_en", sda_en, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rx", {rx_valid, rx_data}, 0);
    chk("const_outs", {scl_out, sda_out}, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", tx_ready, 1);

    // Single byte 0xA5: 22 phases of W cycles.
    exp_ev = {EV_START, 32'hA5, EV_STOP};
    exp_busy.push_back((3 + 19) * W);
    send_frame(32'h000000A5, 1, 1'b0, -1, 0);
    wait_idle();
    chk("a5_err", err, 0);

    // Three bytes with a 10-cycle stall before byte 2; each LOAD visit costs its accept cycle.
    exp_ev = {EV_START, 32'h11, 32'h80, 32'hFE, EV_STOP};
    exp_busy.push_back((3 + 19 * 3) * W + 2 + 10);
    send_frame(32'h00FE8011, 3, 1'b0, 1, 10);
    wait_idle();

    // Write 0x42 then read 0x3C from the slave.
    slave_rd_idx = 1; slave_rd_val = 8'h3C; rxp_cnt = 0;
    exp_ev = {EV_START, 32'h42, EV_RD | 32'h3C, EV_STOP};
    exp_busy.push_back((3 + 19 + 19) * W);
    exp_rx.push_back(8'h3C);
    send_frame(32'h00000042, 1, 1'b1, -1, 0);
    wait_idle();
    chk("rx_pulses", rxp_cnt, 1);
    chk("rx_hold", rx_data, 8'h3C);
    slave_rd_idx = -1;

    // tx_valid held high across a 2-byte frame.
    hs_cnt = 0;
    exp_ev = {EV_START, 32'h5A, 32'hC3, EV_STOP};
    exp_busy.push_back((3 + 19 * 2) * W + 1);
    send_frame(32'h0000C35A, 2, 1'b0, -1, 0);
    wait_idle();
    chk("handshakes_2", hs_cnt, 2);

`ifdef TM1637_ACK_CHECK_EN
    // NAK on first byte: STOP after it, bytes 2-3 drained silently.
    slave_nak_idx = 0; hs_cnt = 0;
    exp_ev = {EV_START, 32'h01, EV_STOP};
    exp_busy.push_back((3 + 19) * W);
    send_frame(32'h00030201, 3, 1'b0, -1, 0);
    wait_idle();
    chk("nak_err", err, 1);
    chk("nak_handshakes", hs_cnt, 3);
    chk("nak_ready_idle", tx_ready, 1);
    slave_nak_idx = -1;
    exp_ev = {EV_START, 32'h77, EV_STOP};
    exp_busy.push_back((3 + 19) * W);
    send_frame(32'h00000077, 1, 1'b0, -1, 0);
    repeat (2) @(negedge clk);
    chk("err_cleared", err, 0);
    wait_idle();
`else
    // Without ACK checking a missing ACK is ignored.
    slave_nak_idx = 0;
    exp_ev = {EV_START, 32'h01, 32'h02, EV_STOP};
    exp_busy.push_back((3 + 19 * 2) * W + 1);
    send_frame(32'h00000201, 2, 1'b0, -1, 0);
    wait_idle();
    chk("noack_err", err, 0);
    slave_nak_idx = -1;
`endif

    // Reset in the middle of bit 0's SCL-high phase.
    mon_en = 1'b0;
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b1; tx_read = 1'b0;
    @(posedge clk); #1 tx_valid = 1'b0; tx_last = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_scl", scl_en, 0);
    @(negedge clk);
    chk("post_rst_bus", {scl_en, sda_en}, 0);
    chk("post_rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    exp_ev = {EV_START, 32'h96, EV_STOP};
    exp_busy.push_back((3 + 19) * W);
    send_frame(32'h00000096, 1, 1'b0, -1, 0);
    wait_idle();

    chk("ready_outside_load", viol, 0);
    chk("ev_queue_empty", exp_ev.size(), 0);
    chk("busy_queue_empty", exp_busy.size(), 0);
    chk("rx_queue_empty", exp_rx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
